// File: rtl/mem_burst_ctrl_if.sv
// Command, write/read data and memory-port bundle shared by a burst master and mem_burst_ctrl.
interface mem_burst_ctrl_if #(
  parameter int NUM_RAMS = 16,
  parameter int D_WID    = 8,
  parameter int LEN_WID  = 16
);
  localparam int DW = NUM_RAMS * D_WID;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_rdwr;
  logic [31:0]        cmd_addr;
  logic [LEN_WID-1:0] cmd_len;

  logic               wr_valid;
  logic               wr_ready;
  logic [DW-1:0]      wr_data;

  logic               rd_valid;
  logic               rd_ready;
  logic [DW-1:0]      rd_data;
  logic [4:0]         rd_bytes;
  logic               rd_last;

  logic               done;
  logic               busy;

  logic               mem_en;
  logic               mem_rdwr;
  logic [4:0]         mem_control;
  logic [31:0]        mem_addr;
  logic [DW-1:0]      mem_wr_data;
  logic [DW-1:0]      mem_rd_data;

  modport slave (
    input  cmd_valid, cmd_rdwr, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, mem_rd_data,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_bytes, rd_last,
    output done, busy, mem_en, mem_rdwr, mem_control, mem_addr, mem_wr_data
  );

  modport master (
    output cmd_valid, cmd_rdwr, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, mem_rd_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_bytes, rd_last,
    input  done, busy, mem_en, mem_rdwr, mem_control, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Splits byte-addressed transfer commands into beats of up to NUM_RAMS bytes for the
// scratchpad's unaligned port, with a credit-limited FIFO absorbing read backpressure.
module mem_burst_ctrl #(
  parameter int NUM_RAMS = 16,
  parameter int D_WID    = 8,
  parameter int LEN_WID  = 16,
  parameter int RD_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  mem_burst_ctrl_if.slave bus
);
  localparam int DW   = NUM_RAMS * D_WID;
  localparam int CTLW = 5;
  localparam int PW   = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int CW   = $clog2(RD_DEPTH + 1);

  localparam logic [CTLW-1:0]    FULL_BEAT = CTLW'(NUM_RAMS);
  localparam logic [LEN_WID-1:0] LEN_FULL  = LEN_WID'(NUM_RAMS);
  localparam logic [PW-1:0]      LAST_PTR  = PW'(RD_DEPTH - 1);
  localparam logic [CW:0]        DEPTH_L   = (CW + 1)'(RD_DEPTH);

  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_e;

  state_e             state_q;
  logic [31:0]        curAddr_q, curAddr_d;
  logic [LEN_WID-1:0] remaining_q, remaining_d;
  logic               inflight_q;
  logic [CTLW-1:0]    inflightBytes_q;
  logic               inflightLast_q;
  logic               memRdwr_q;
  logic [CTLW-1:0]    memControl_q;
  logic [31:0]        memAddr_q;

  logic [DW-1:0]      fifoData_q  [RD_DEPTH];
  logic [CTLW-1:0]    fifoBytes_q [RD_DEPTH];
  logic               fifoLast_q  [RD_DEPTH];
  logic [PW-1:0]      wrPtr_q, rdPtr_q;
  logic [CW-1:0]      count_q, count_d;

  logic [CTLW-1:0]    beat;
  logic               lastBeat;
  logic [CW:0]        outstanding;
  logic               wrIssue, rdIssue, issue;
  logic               push, pop, headLast;

  assign beat        = (remaining_q >= LEN_FULL) ? FULL_BEAT : remaining_q[CTLW-1:0];
  assign lastBeat    = (remaining_q <= LEN_FULL);
  assign curAddr_d   = curAddr_q + 32'(beat);
  assign remaining_d = remaining_q - LEN_WID'(beat);

  // A read may issue only while every FIFO slot it could need is still free.
  assign outstanding = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign wrIssue     = (state_q == WR) && bus.wr_valid;
  assign rdIssue     = (state_q == RD) && (outstanding < DEPTH_L);
  assign issue       = wrIssue || rdIssue;

  assign push        = inflight_q;
  assign pop         = (count_q != '0) && bus.rd_ready;
  assign headLast    = fifoLast_q[rdPtr_q];

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.wr_ready    = (state_q == WR);

  assign bus.mem_en      = issue;
  assign bus.mem_rdwr    = issue ? wrIssue   : memRdwr_q;
  assign bus.mem_control = issue ? beat      : memControl_q;
  assign bus.mem_addr    = issue ? curAddr_q : memAddr_q;
  assign bus.mem_wr_data = bus.wr_data;

  assign bus.rd_valid    = (count_q != '0);
  assign bus.rd_data     = fifoData_q[rdPtr_q];
  assign bus.rd_bytes    = bus.rd_valid ? fifoBytes_q[rdPtr_q] : '0;
  assign bus.rd_last     = bus.rd_valid && headLast;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      curAddr_q       <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflightBytes_q <= '0;
      inflightLast_q  <= 1'b0;
      memRdwr_q       <= 1'b0;
      memControl_q    <= '0;
      memAddr_q       <= '0;
    end else begin
      inflight_q <= rdIssue;
      if (rdIssue) begin
        inflightBytes_q <= beat;
        inflightLast_q  <= lastBeat;
      end
      if (issue) begin
        memRdwr_q    <= wrIssue;
        memControl_q <= beat;
        memAddr_q    <= curAddr_q;
        curAddr_q    <= curAddr_d;
        remaining_q  <= remaining_d;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            curAddr_q   <= bus.cmd_addr;
            remaining_q <= bus.cmd_len;
            state_q     <= (bus.cmd_len == '0) ? DONE : (bus.cmd_rdwr ? WR : RD);
          end
        end
        WR:      if (wrIssue && lastBeat) state_q <= DONE;
        RD:      if (rdIssue && lastBeat) state_q <= DRAIN;
        DRAIN:   if (pop && headLast)     state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wrPtr_q <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
    end
  end

  // Storage needs no reset: everything read from it is qualified by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoData_q[wrPtr_q]  <= bus.mem_rd_data;
      fifoBytes_q[wrPtr_q] <= inflightBytes_q;
      fifoLast_q[wrPtr_q]  <= inflightLast_q;
    end
  end
endmodule
